// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the core-to-sram-like bus bridge.
// State codes, transfer sizes and byte-enable size decode.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  // Non-power-of-two enable patterns fall back to a full-width access.
  function automatic logic [1:0] be_to_size(
    input logic [7:0] be,
    input logic [1:0] full
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += 32'(be[i]);
    end
    case (n)
      1:       return SIZE_BYTE;
      2:       return SIZE_HALF;
      4:       return SIZE_WORD;
      8:       return SIZE_DWORD;
      default: return full;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_channel.sv
// One sram-like request channel: FSM, request latch, response buffer.
// Holds a response until the pipeline advances; drains flushed requests.
module sram_like_channel
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              hold,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    bus_req = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus_req = en & ~flush;
        stall   = en;
        // A same-cycle accept may already be in flight, so drain it.
        if (en && bus_addr_ok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
          wr_d    = wr_i;
          size_d  = size_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            buf_d   = bus_rdata;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!hold) state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (bus_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      bus_wr    = wr_i;
      bus_size  = size_i;
      bus_addr  = addr_i;
      bus_wdata = wdata_i;
    end else begin
      bus_wr    = wr_q;
      bus_size  = size_q;
      bus_addr  = addr_q;
      bus_wdata = wdata_q;
    end
  end

  assign rdata_o = buf_q;

endmodule

// File: rtl/cpu_sram_like_bridge.sv
// Core fetch/data ports to two sram-like buses.
// Adds transfer-size encoding around two channel instances.
module cpu_sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              longest_stall,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] pcF,
  input  logic              inst_flush,
  output logic [DATA_W-1:0] instrF,
  output logic              i_stall,
  input  logic              data_en,
  input  logic [BE_W-1:0]   memwriteEN,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              hasException,
  output logic [DATA_W-1:0] readdataM,
  output logic              d_stall,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_wdata,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam logic [1:0] SIZE_FULL =
    (DATA_W == 64) ? SIZE_DWORD : SIZE_WORD;

  logic [7:0] be_ext;
  logic       d_wr;
  logic [1:0] d_size;

  always_comb begin
    be_ext = '0;
    be_ext[BE_W-1:0] = memwriteEN;
    d_wr   = |memwriteEN;
    d_size = d_wr ? be_to_size(be_ext, SIZE_FULL) : SIZE_FULL;
  end

  sram_like_channel #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_inst (
    .clk        (clk),
    .rst        (rst),
    .en         (inst_en),
    .flush      (inst_flush),
    .hold       (longest_stall),
    .wr_i       (1'b0),
    .size_i     (SIZE_FULL),
    .addr_i     (pcF),
    .wdata_i    ({DATA_W{1'b0}}),
    .rdata_o    (instrF),
    .stall      (i_stall),
    .bus_req    (inst_req),
    .bus_wr     (inst_wr),
    .bus_size   (inst_size),
    .bus_addr   (inst_addr),
    .bus_wdata  (inst_wdata),
    .bus_addr_ok(inst_addr_ok),
    .bus_data_ok(inst_data_ok),
    .bus_rdata  (inst_rdata)
  );

  sram_like_channel #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_data (
    .clk        (clk),
    .rst        (rst),
    .en         (data_en),
    .flush      (hasException),
    .hold       (longest_stall),
    .wr_i       (d_wr),
    .size_i     (d_size),
    .addr_i     (aluoutM),
    .wdata_i    (writedataM),
    .rdata_o    (readdataM),
    .stall      (d_stall),
    .bus_req    (data_req),
    .bus_wr     (data_wr),
    .bus_size   (data_size),
    .bus_addr   (data_addr),
    .bus_wdata  (data_wdata),
    .bus_addr_ok(data_addr_ok),
    .bus_data_ok(data_data_ok),
    .bus_rdata  (data_rdata)
  );

endmodule

// File: tb/tb_cpu_sram_like_bridge.sv
// Directed bench for cpu_sram_like_bridge.
// Size/enable vector table plus multi-cycle handshake sequences.
module tb_cpu_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        longest_stall;
  logic        inst_en;
  logic [31:0] pcF;
  logic        inst_flush;
  logic [31:0] instrF;
  logic        i_stall;
  logic        data_en;
  logic [3:0]  memwriteEN;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        hasException;
  logic [31:0] readdataM;
  logic        d_stall;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_sram_like_bridge #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .longest_stall(longest_stall),
    .inst_en      (inst_en),
    .pcF          (pcF),
    .inst_flush   (inst_flush),
    .instrF       (instrF),
    .i_stall      (i_stall),
    .data_en      (data_en),
    .memwriteEN   (memwriteEN),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .hasException (hasException),
    .readdataM    (readdataM),
    .d_stall      (d_stall),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  typedef struct {
    logic [3:0] be;
    logic       exc;
    logic       req;
    logic       wr;
    logic [1:0] size;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one cycle; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[1] = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0};
    vt[2] = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd0};
    vt[3] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1};
    vt[4] = '{4'b1100, 1'b0, 1'b1, 1'b1, 2'd1};
    vt[5] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd2};
    vt[6] = '{4'b0111, 1'b0, 1'b1, 1'b1, 2'd2};
    vt[7] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0};

    rst = 1'b0;
    longest_stall = 1'b0;
    inst_en = 1'b0;
    pcF = '0;
    inst_flush = 1'b0;
    data_en = 1'b0;
    memwriteEN = '0;
    aluoutM = '0;
    writedataM = '0;
    hasException = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
    repeat (2) tick();
    chk("rst_i_stall", 32'(i_stall), 0);
    chk("rst_d_stall", 32'(d_stall), 0);
    chk("rst_inst_req", 32'(inst_req), 0);
    chk("rst_data_req", 32'(data_req), 0);
    chk("rst_instrF", instrF, 0);
    chk("rst_readdataM", readdataM, 0);
    rst = 1'b1;
    tick();

    // IDLE request decode, no handshake
    data_en = 1'b1;
    aluoutM = 32'h1000_0003;
    for (int i = 0; i < 8; i++) begin
      memwriteEN = vt[i].be;
      hasException = vt[i].exc;
      #2;
      chk($sformatf("vec%0d_req", i), 32'(data_req), 32'(vt[i].req));
      chk($sformatf("vec%0d_wr", i), 32'(data_wr), 32'(vt[i].wr));
      chk($sformatf("vec%0d_size", i), 32'(data_size), 32'(vt[i].size));
      chk($sformatf("vec%0d_stall", i), 32'(d_stall), 1);
      chk($sformatf("vec%0d_addr", i), data_addr, 32'h1000_0003);
      tick();
    end
    data_en = 1'b0;
    memwriteEN = '0;
    hasException = 1'b0;
    tick();

    // Fetch with 3-cycle data_ok latency
    inst_en = 1'b1;
    pcF = 32'h0000_0100;
    inst_addr_ok = 1'b1;
    #2;
    chk("f_req", 32'(inst_req), 1);
    chk("f_addr", inst_addr, 32'h100);
    chk("f_size", 32'(inst_size), 2);
    chk("f_wr", 32'(inst_wr), 0);
    chk("f_stall0", 32'(i_stall), 1);
    tick();
    inst_addr_ok = 1'b0;
    #2;
    chk("f_req_wait", 32'(inst_req), 0);
    chk("f_stall1", 32'(i_stall), 1);
    tick();
    chk("f_stall2", 32'(i_stall), 1);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'h1234_5678;
    #2;
    chk("f_stall3", 32'(i_stall), 1);
    tick();
    inst_data_ok = 1'b0;
    inst_en = 1'b0;
    #2;
    chk("f_stall4", 32'(i_stall), 0);
    chk("f_instr", instrF, 32'h1234_5678);
    tick();
    chk("f_idle_stall", 32'(i_stall), 0);
    chk("f_idle_instr", instrF, 32'h1234_5678);

    // Half-word store
    data_en = 1'b1;
    memwriteEN = 4'b0011;
    aluoutM = 32'h8000_0002;
    writedataM = 32'h0000_BEEF;
    data_addr_ok = 1'b1;
    #2;
    chk("st_req", 32'(data_req), 1);
    chk("st_wr", 32'(data_wr), 1);
    chk("st_size", 32'(data_size), 1);
    chk("st_addr", data_addr, 32'h8000_0002);
    chk("st_wdata", data_wdata, 32'h0000_BEEF);
    tick();
    data_addr_ok = 1'b0;
    #2;
    chk("st_wait_req", 32'(data_req), 0);
    chk("st_wait_stall", 32'(d_stall), 1);
    tick();
    data_data_ok = 1'b1;
    #2;
    chk("st_ack_stall", 32'(d_stall), 1);
    tick();
    data_data_ok = 1'b0;
    data_en = 1'b0;
    memwriteEN = '0;
    #2;
    chk("st_done_stall", 32'(d_stall), 0);
    tick();

    // Load, then hold DONE under longest_stall
    data_en = 1'b1;
    aluoutM = 32'h0000_0040;
    data_addr_ok = 1'b1;
    #2;
    chk("ld_size", 32'(data_size), 2);
    chk("ld_wr", 32'(data_wr), 0);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'hCAFE_F00D;
    tick();
    data_data_ok = 1'b0;
    data_rdata = 32'h1111_1111;
    longest_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("hold%0d_stall", c), 32'(d_stall), 0);
      chk($sformatf("hold%0d_req", c), 32'(data_req), 0);
      chk($sformatf("hold%0d_data", c), readdataM, 32'hCAFE_F00D);
      tick();
    end
    longest_stall = 1'b0;
    tick();
    aluoutM = 32'h0000_0044;
    data_addr_ok = 1'b1;
    #2;
    chk("next_req", 32'(data_req), 1);
    chk("next_addr", data_addr, 32'h44);

    // Exception while waiting
    tick();
    data_addr_ok = 1'b0;
    hasException = 1'b1;
    #2;
    chk("exc_wait_stall", 32'(d_stall), 1);
    tick();
    hasException = 1'b0;
    data_en = 1'b0;
    #2;
    chk("drain_stall", 32'(d_stall), 1);
    chk("drain_req", 32'(data_req), 0);
    tick();
    data_data_ok = 1'b1;
    data_rdata = 32'h5555_5555;
    #2;
    chk("drain_ok_stall", 32'(d_stall), 1);
    tick();
    data_data_ok = 1'b0;
    #2;
    chk("drain_idle_stall", 32'(d_stall), 0);
    chk("drain_buf", readdataM, 32'hCAFE_F00D);
    data_en = 1'b1;
    #1;
    chk("drain_idle_req", 32'(data_req), 1);
    data_en = 1'b0;
    tick();

    // addr_ok coincident with inst_flush
    inst_en = 1'b1;
    inst_flush = 1'b1;
    inst_addr_ok = 1'b1;
    pcF = 32'h0000_0200;
    #2;
    chk("fl_req", 32'(inst_req), 0);
    chk("fl_stall", 32'(i_stall), 1);
    tick();
    inst_flush = 1'b0;
    inst_addr_ok = 1'b0;
    pcF = 32'h0000_0300;
    #2;
    chk("fl_drain_stall", 32'(i_stall), 1);
    chk("fl_drain_req", 32'(inst_req), 0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'hBADB_AD00;
    tick();
    inst_data_ok = 1'b0;
    #2;
    chk("fl_next_req", 32'(inst_req), 1);
    chk("fl_next_addr", inst_addr, 32'h300);
    chk("fl_keep_instr", instrF, 32'h1234_5678);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'h0BAD_F00D;
    tick();
    inst_data_ok = 1'b0;
    inst_en = 1'b0;
    #2;
    chk("fl_new_instr", instrF, 32'h0BAD_F00D);
    chk("fl_new_stall", 32'(i_stall), 0);
    tick();

    // Reset while a load is outstanding
    data_en = 1'b1;
    aluoutM = 32'h0000_0080;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_en = 1'b0;
    #2;
    chk("rw_stall", 32'(d_stall), 1);
    rst = 1'b0;
    #1;
    chk("rw_rst_stall", 32'(d_stall), 0);
    chk("rw_rst_req", 32'(data_req), 0);
    chk("rw_rst_buf", readdataM, 0);
    chk("rw_rst_instr", instrF, 0);
    tick();
    rst = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'h7777_7777;
    tick();
    data_data_ok = 1'b0;
    #2;
    chk("stray_stall", 32'(d_stall), 0);
    chk("stray_buf", readdataM, 0);
    chk("stray_req", 32'(data_req), 0);
    data_en = 1'b1;
    #1;
    chk("stray_idle", 32'(d_stall), 1);
    data_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
